// File: rtl/bist_c1tx_sched.sv
// Round-robin write scheduler for the BIST AFU C1Tx path: engines share one request FIFO,
// the FIFO head is drained to CCI-P C1Tx, and per-engine outstanding writes are tracked.
module bist_c1tx_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 556,
   parameter int ID_WIDTH   = 2,
   parameter int MAX_OUTST  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_grant,
   output logic [DATA_WIDTH-1:0]           fifo_din,
   output logic [ID_WIDTH-1:0]             fifo_ctlin,
   output logic                            fifo_wen,
   output logic                            fifo_rdack,
   input  logic                            T0_fifo_dout_v,
   input  logic [ID_WIDTH-1:0]             T0_fifo_ctlout,
   input  logic                            T0_fifo_almFull,
   input  logic [DATA_WIDTH-1:0]           T2_fifo_dout,
   input  logic                            c1TxAlmFull,
   output logic                            c1Tx_valid,
   output logic [DATA_WIDTH-1:0]           c1Tx_data,
   output logic [ID_WIDTH-1:0]             c1Tx_id,
   input  logic                            rsp_valid,
   input  logic [ID_WIDTH-1:0]             rsp_id,
   output logic [NUM_REQ*CNT_WIDTH-1:0]    outst_cnt,
   output logic                            idle,
   output logic                            rsp_err
);

   logic [CNT_WIDTH-1:0] cnt [NUM_REQ];
   logic [NUM_REQ-1:0]   eligible;
   logic [ID_WIDTH-1:0]  rr_ptr;
   logic [ID_WIDTH-1:0]  grant_idx;
   logic                 found;
   logic                 all_zero;
   logic                 vld_p1, vld_p2;
   logic [ID_WIDTH-1:0]  id_p1, id_p2;

   function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base, input int ofs);
      int s;
      s = int'(base) + ofs;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_WIDTH'(s);
   endfunction

   always_comb begin
      eligible = '0;
      all_zero = 1'b1;
      outst_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (cnt[i] < CNT_WIDTH'(MAX_OUTST));
         if (cnt[i] != '0) all_zero = 1'b0;
         outst_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
      end
   end

   // First eligible engine at or after rr_ptr wins; almFull blocks the push entirely.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && eligible[wrap_idx(rr_ptr, k)]) begin
            found     = 1'b1;
            grant_idx = wrap_idx(rr_ptr, k);
         end
      end
   end

   always_comb begin
      req_grant = '0;
      fifo_wen  = 1'b0;
      if (found && !T0_fifo_almFull && !Reset) begin
         req_grant[grant_idx] = 1'b1;
         fifo_wen             = 1'b1;
      end
   end

   assign fifo_din   = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign fifo_ctlin = grant_idx;
   assign fifo_rdack = T0_fifo_dout_v && !c1TxAlmFull && !Reset;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rr_ptr <= '0;
      end else if (fifo_wen) begin
         rr_ptr <= (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + ID_WIDTH'(1);
      end
   end

   // A grant and a response to the same engine in one cycle cancel out.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
         rsp_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i] && !(rsp_valid && rsp_id == ID_WIDTH'(i))) begin
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end else if (!req_grant[i] && rsp_valid && rsp_id == ID_WIDTH'(i)) begin
               if (cnt[i] == '0) rsp_err <= 1'b1;
               else              cnt[i]  <= cnt[i] - CNT_WIDTH'(1);
            end
         end
      end
   end

   // Stage p1/p2: carry valid and id alongside the FIFO's two-cycle data read latency
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= fifo_rdack;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge Clk) begin
      id_p1 <= T0_fifo_ctlout;
      id_p2 <= id_p1;
   end

   // Stage p3: id and data realigned onto the C1Tx port
   always_ff @(posedge Clk) begin
      if (Reset) begin
         c1Tx_valid <= 1'b0;
         c1Tx_data  <= '0;
         c1Tx_id    <= '0;
         idle       <= 1'b1;
      end else begin
         c1Tx_valid <= vld_p2;
         c1Tx_data  <= T2_fifo_dout;
         c1Tx_id    <= id_p2;
         idle       <= all_zero && !T0_fifo_dout_v && !vld_p1 && !vld_p2 && !c1Tx_valid;
      end
   end

endmodule

// File: tb/tb_bist_c1tx_sched.sv
// Directed bench for bist_c1tx_sched with a behavioural request FIFO (2-cycle data latency).
module tb_bist_c1tx_sched;
   localparam int NR = 4;
   localparam int DW = 556;
   localparam int IW = 2;
   localparam int CW = 8;

   logic              Clk;
   logic              Reset;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_grant;
   logic [DW-1:0]     fifo_din;
   logic [IW-1:0]     fifo_ctlin;
   logic              fifo_wen;
   logic              fifo_rdack;
   logic              fv;
   logic [IW-1:0]     fid;
   logic              T0_fifo_almFull;
   logic [DW-1:0]     t1, t2;
   logic              c1TxAlmFull;
   logic              c1Tx_valid;
   logic [DW-1:0]     c1Tx_data;
   logic [IW-1:0]     c1Tx_id;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [NR*CW-1:0]  outst_cnt;
   logic              idle;
   logic              rsp_err;

   int nvec = 0;
   int nerr = 0;

   logic [IW-1:0] q_id [$];
   logic [DW-1:0] q_dat [$];
   int            mon_id [$];
   int            mon_dat [$];

   bist_c1tx_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTST(16), .CNT_WIDTH(CW)) dut (
      .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_data(req_data), .req_grant(req_grant),
      .fifo_din(fifo_din), .fifo_ctlin(fifo_ctlin), .fifo_wen(fifo_wen), .fifo_rdack(fifo_rdack),
      .T0_fifo_dout_v(fv), .T0_fifo_ctlout(fid), .T0_fifo_almFull(T0_fifo_almFull),
      .T2_fifo_dout(t2), .c1TxAlmFull(c1TxAlmFull), .c1Tx_valid(c1Tx_valid), .c1Tx_data(c1Tx_data),
      .c1Tx_id(c1Tx_id), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .outst_cnt(outst_cnt),
      .idle(idle), .rsp_err(rsp_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Request FIFO model: head visible the cycle after a push, data two cycles after a pop.
   always @(posedge Clk) begin
      if (Reset) begin
         q_id.delete();
         q_dat.delete();
         fv  <= 1'b0;
         fid <= '0;
         t1  <= '0;
         t2  <= '0;
      end else begin
         if (fifo_rdack && q_id.size() > 0) begin
            t1 <= q_dat[0];
            void'(q_id.pop_front());
            void'(q_dat.pop_front());
         end
         if (fifo_wen) begin
            q_id.push_back(fifo_ctlin);
            q_dat.push_back(fifo_din);
         end
         t2  <= t1;
         fv  <= (q_id.size() > 0);
         fid <= (q_id.size() > 0) ? q_id[0] : '0;
      end
   end

   always @(negedge Clk) begin
      if (!Reset && c1Tx_valid) begin
         mon_id.push_back(int'(c1Tx_id));
         mon_dat.push_back(int'(c1Tx_data[15:0]));
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      @(negedge Clk);
   endtask

   task automatic set_data();
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(16'h00B0 + i);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      req_valid = '0;
      rsp_valid = 1'b0;
      rsp_id = '0;
      c1TxAlmFull = 1'b0;
      T0_fifo_almFull = 1'b0;
      set_data();
      step();
      step();
      mon_id.delete();
      mon_dat.delete();
      Reset = 1'b0;
   endtask

   initial begin
      int ng;
      int bad;
      Reset = 1'b1;
      req_valid = '0;
      rsp_valid = 1'b0;
      rsp_id = '0;
      c1TxAlmFull = 1'b0;
      T0_fifo_almFull = 1'b0;
      set_data();

      // Reset state; grants stay low during reset even with requests pending
      step();
      req_valid = 4'hF;
      settle();
      check("rst_grant", 64'(req_grant), 64'h0);
      check("rst_wen", 64'(fifo_wen), 64'h0);
      step();
      req_valid = '0;
      Reset = 1'b0;
      step();
      settle();
      check("rst_idle", 64'(idle), 64'h1);
      check("rst_c1tx_valid", 64'(c1Tx_valid), 64'h0);
      check("rst_cnt", 64'(outst_cnt), 64'h0);
      check("rst_grant_after", 64'(req_grant), 64'h0);

      // Round robin across all four engines
      step();
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         settle();
         check($sformatf("rr_grant%0d", k), 64'(req_grant), 64'(1 << (k % 4)));
         check($sformatf("rr_ctlin%0d", k), 64'(fifo_ctlin), 64'(k % 4));
         check($sformatf("rr_din%0d", k), 64'(fifo_din[15:0]), 64'(16'h00B0 + (k % 4)));
         step();
      end
      req_valid = '0;
      settle();
      check("rr_cnt", 64'(outst_cnt), 64'h02020202);
      repeat (16) step();
      check("rr_drain_n", 64'(mon_id.size()), 64'd8);
      if (mon_id.size() == 8) begin
         for (int k = 0; k < 8; k++) check($sformatf("rr_drain_id%0d", k), 64'(mon_id[k]), 64'(k % 4));
      end

      // Single push: pop the cycle head goes valid, C1Tx three clocks later
      do_reset();
      req_data[2*DW +: DW] = DW'(8'hA5);
      req_valid = 4'b0100;
      settle();
      check("one_grant", 64'(req_grant), 64'h4);
      check("one_rdack_early", 64'(fifo_rdack), 64'h0);
      step();
      req_valid = '0;
      settle();
      check("one_rdack", 64'(fifo_rdack), 64'h1);
      step();
      settle();
      check("one_vld_p1", 64'(c1Tx_valid), 64'h0);
      step();
      settle();
      check("one_vld_p2", 64'(c1Tx_valid), 64'h0);
      step();
      settle();
      check("one_vld", 64'(c1Tx_valid), 64'h1);
      check("one_id", 64'(c1Tx_id), 64'h2);
      check("one_data", c1Tx_data[63:0], 64'hA5);
      step();
      settle();
      check("one_vld_off", 64'(c1Tx_valid), 64'h0);

      // Outstanding limit on engine 1
      do_reset();
      req_valid = 4'b0010;
      ng = 0;
      repeat (20) begin
         settle();
         if (req_grant[1]) ng++;
         step();
      end
      check("lim_grants", 64'(ng), 64'd16);
      settle();
      check("lim_blocked", 64'(req_grant), 64'h0);
      check("lim_cnt", 64'(outst_cnt[15:8]), 64'd16);
      step();
      rsp_valid = 1'b1;
      rsp_id = 2'd1;
      settle();
      check("lim_rsp_cycle", 64'(req_grant), 64'h0);
      step();
      rsp_valid = 1'b0;
      settle();
      check("lim_regrant", 64'(req_grant), 64'h2);
      step();
      settle();
      check("lim_reblock", 64'(req_grant), 64'h0);

      // Simultaneous grant and response; response to an idle engine
      do_reset();
      req_valid = 4'b0001;
      repeat (5) step();
      rsp_valid = 1'b1;
      rsp_id = 2'd0;
      settle();
      check("both_grant", 64'(req_grant), 64'h1);
      step();
      rsp_valid = 1'b0;
      req_valid = '0;
      settle();
      check("both_cnt", 64'(outst_cnt[7:0]), 64'd5);
      check("err_before", 64'(rsp_err), 64'h0);
      step();
      rsp_valid = 1'b1;
      rsp_id = 2'd3;
      step();
      rsp_valid = 1'b0;
      settle();
      check("err_set", 64'(rsp_err), 64'h1);
      check("err_cnt3", 64'(outst_cnt[31:24]), 64'h0);
      repeat (3) step();
      settle();
      check("err_sticky", 64'(rsp_err), 64'h1);
      do_reset();
      settle();
      check("err_cleared", 64'(rsp_err), 64'h0);

      // Downstream back-pressure with four queued entries
      step();
      c1TxAlmFull = 1'b1;
      req_valid = 4'hF;
      repeat (4) step();
      req_valid = '0;
      bad = 0;
      repeat (5) begin
         settle();
         if (fifo_rdack) bad++;
         step();
      end
      check("bp_rdack_held", 64'(bad), 64'h0);
      check("bp_no_issue", 64'(mon_id.size()), 64'h0);
      c1TxAlmFull = 1'b0;
      settle();
      check("bp_one_pop", 64'(fifo_rdack), 64'h1);
      step();
      c1TxAlmFull = 1'b1;
      repeat (6) step();
      check("bp_inflight", 64'(mon_id.size()), 64'd1);
      c1TxAlmFull = 1'b0;
      repeat (12) step();
      settle();
      check("bp_total", 64'(mon_id.size()), 64'd4);
      if (mon_id.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_id%0d", k), 64'(mon_id[k]), 64'(k));
            check($sformatf("bp_dat%0d", k), 64'(mon_dat[k]), 64'(16'h00B0 + k));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/bist_c1tx_sched.md
Name: bist_c1tx_sched

Overview:
- Write-channel scheduler for the BIST AFU C1Tx path.
- Shares one C1Tx request FIFO among NUM_REQ test engines using round-robin arbitration.
- Drains the FIFO toward the CCI-P C1Tx port under c1TxAlmFull back-pressure and realigns the FIFO's control/data skew (control at T0, data at T2).
- Tracks outstanding writes per requester, so each engine has at most MAX_OUTST writes in flight until write responses return.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..8).
- DATA_WIDTH, 556, request payload width (header plus data).
- ID_WIDTH, 2, requester id width; must be at least clog2(NUM_REQ).
- MAX_OUTST, 16, maximum writes in flight per requester (1..255).
- CNT_WIDTH, 8, outstanding-counter width; must be at least clog2(MAX_OUTST+1).

Ports:
- Clk  in  1  global clock
- Reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request pending per engine
- req_data  in  NUM_REQ*DATA_WIDTH  payload; engine i owns slice i
- req_grant  out  NUM_REQ  one-hot accept, combinational, same cycle
- fifo_din  out  DATA_WIDTH  to FIFO fifo_din
- fifo_ctlin  out  ID_WIDTH  granted id, to FIFO fifo_ctlin
- fifo_wen  out  1  FIFO write enable
- fifo_rdack  out  1  FIFO pop
- T0_fifo_dout_v  in  1  FIFO head valid
- T0_fifo_ctlout  in  ID_WIDTH  head id
- T0_fifo_almFull  in  1  FIFO almost full
- T2_fifo_dout  in  DATA_WIDTH  FIFO data, 2 clks after pop
- c1TxAlmFull  in  1  downstream back-pressure
- c1Tx_valid  out  1  write request valid
- c1Tx_data  out  DATA_WIDTH  write request payload
- c1Tx_id  out  ID_WIDTH  originating engine
- rsp_valid  in  1  write response
- rsp_id  in  ID_WIDTH  response owner
- outst_cnt  out  NUM_REQ*CNT_WIDTH  per-engine in-flight count
- idle  out  1  nothing queued or in flight
- rsp_err  out  1  sticky: response received for an engine whose count is 0

Behaviour:
- Reset is synchronous. On reset the following are cleared in the same edge:
  - rr_ptr = 0
  - all counters = 0
  - pipeline valids = 0
  - c1Tx_valid = 0, c1Tx_data = 0, c1Tx_id = 0
  - rsp_err = 0
- Combinational outputs are 0 while Reset is high: req_grant, fifo_wen, fifo_rdack.
- idle = 1 after reset.
- Eligibility: eligible[i] = req_valid[i] & (cnt[i] < MAX_OUTST).
- Arbitration: search from rr_ptr upward with wrap. The first eligible engine i is granted only if T0_fifo_almFull = 0.
  - req_grant[i] = 1, fifo_wen = 1, fifo_din = slice i, fifo_ctlin = i.
  - On the next edge rr_ptr <= i+1, wrapping from NUM_REQ-1 to 0.
  - With no grant, rr_ptr holds.
  - At most one grant per cycle.
- Throughput: T0_fifo_almFull must be set with headroom of at least 1 entry, because the push is combinational. One push per clock is sustained while almFull = 0.
- Drain: fifo_rdack = T0_fifo_dout_v & ~c1TxAlmFull.
  - On pop, stage-1 captures (valid, T0_fifo_ctlout).
  - Stage-2 shifts from stage-1.
  - Stage-3 outputs: c1Tx_valid <= stage-2 valid, c1Tx_data <= T2_fifo_dout, c1Tx_id <= stage-2 id.
  - Pop-to-c1Tx_valid latency = 3 clks. Back-to-back pops give back-to-back c1Tx_valid.
- c1TxAlmFull deassertion takes effect in the same cycle. Up to 3 requests already in the pipeline still issue after it asserts; the CCI-P allowance covers this.
- Counters, per engine: +1 on req_grant[i]; -1 on rsp_valid & rsp_id = i.
  - Both in the same cycle: unchanged.
  - Response when cnt = 0: count stays 0 and rsp_err <= 1.
  - Counters never exceed MAX_OUTST.
- idle = all cnt = 0 & ~T0_fifo_dout_v & no pipeline valid & ~c1Tx_valid, registered.
- Reset mid-operation: in-flight pipeline entries are discarded. The FIFO must be reset in the same cycle by the parent.

Test Plan:
- Reset with all inputs 0 -> req_grant = 0, c1Tx_valid = 0, idle = 1 one clk after reset, all outst_cnt = 0.
- req_valid = 4'b1111 for 8 clks, almFull = 0, responses off -> grants 0,1,2,3,0,1,2,3, fifo_ctlin matches each grant, and each cnt = 2.
- Single push of id 2 with data 0xA5, c1TxAlmFull = 0 -> fifo_rdack on the cycle T0_fifo_dout_v rises, then c1Tx_valid 3 clks later with c1Tx_id = 2 and c1Tx_data = 0xA5.
- MAX_OUTST = 16, engine 1 streams with no responses -> exactly 16 grants, then req_grant[1] held at 0. One rsp_valid with id 1 -> one more grant on the next eligible cycle.
- Simultaneous grant and response on engine 0 with cnt = 5 -> cnt stays 5. A response to engine 3 with cnt = 0 -> rsp_err = 1 and sticky until reset.
- c1TxAlmFull held 1 with 4 entries queued -> fifo_rdack = 0 and at most 3 c1Tx_valid pulses drain. Deassert -> the remaining entries issue in FIFO order with no loss or duplication.
